// File: rtl/serial_key_seq.sv
// -----------------------------------------------------------------------------
// serial_key_seq
//
// Serial key sequencer. The bus must first present a fixed sequence of
// challenge nibbles inside a decoded read window. Once the sequence is seen,
// the block serves a pseudo-random data bit stream from an LFSR, one bit per
// access. It relocks on a clear nibble or after MAX_BITS bits.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   sser      in   serial-key select, active low
//   ba13      in   window decode bit (must be 0)
//   ba12      in   window decode bit (must be 1)
//   ba_nib    in   challenge nibble [NIB_W]
//   br_w      in   bus read strobe, 1 = read
//   sdrd      out  serial data bit (parity of masked key state)
//   sdrd_oe   out  drive enable for sdrd (access while unlocked)
//   unlocked  out  high while in RUN
//   state     out  current key state [STATE_W]
//   dbg_idx   out  current match index while locked (debug)
//   dbg_cnt   out  bits served in the current RUN session (debug)
//
// Handshake: there is no valid/ready pair here. An access is qualified
// purely by the decode term acc. Exactly one step is taken on the first
// rising edge of each access, however many cycles the access lasts.
// -----------------------------------------------------------------------------
module serial_key_seq #(
  parameter int                   STATE_W    = 6,
  parameter int                   NIB_W      = 4,
  parameter int                   SEQ_LEN    = 4,
  // Room for up to 8 entries. Entry i sits at [i*NIB_W +: NIB_W].
  parameter logic [8*NIB_W-1:0]   UNLOCK_KEY = (8*NIB_W)'(16'h5A3C),
  parameter logic [STATE_W-1:0]   SEED       = STATE_W'(6'b101001),
  parameter logic [STATE_W-1:0]   TAPS       = STATE_W'(6'b101001),
  parameter logic [STATE_W-1:0]   OUT_MASK   = STATE_W'(6'b101001),
  parameter logic [NIB_W-1:0]     CLR_NIB    = NIB_W'(4'hF),
  parameter int                   MAX_BITS   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sser,
  input  logic               ba13,
  input  logic               ba12,
  input  logic [NIB_W-1:0]   ba_nib,
  input  logic               br_w,
  output logic               sdrd,
  output logic               sdrd_oe,
  output logic               unlocked,
  output logic [STATE_W-1:0] state,
  output logic [2:0]         dbg_idx,
  output logic [15:0]        dbg_cnt
);

  localparam int CNT_W = $clog2(MAX_BITS + 1);
  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  typedef enum logic {
    LOCKED = 1'b0,
    RUN    = 1'b1
  } fsm_t;

  fsm_t               fsm_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               acc_q;
  logic [STATE_W-1:0] state_q;
  logic               unlocked_q;

  logic               acc;
  logic               stp;
  logic [NIB_W-1:0]   key_cur;
  logic               nib_hit;
  logic               nib_first;
  logic               is_clr;
  logic               last_bit;
  logic [STATE_W-1:0] lfsr_next;

  // Qualified access and its rising-edge step strobe.
  assign acc = ~sser & ~ba13 & ba12 & br_w;
  assign stp = acc & ~acc_q;

  // Select the key nibble expected at the current match index.
  always_comb begin
    key_cur = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        key_cur = UNLOCK_KEY[i*NIB_W +: NIB_W];
      end
    end
  end

  assign nib_hit   = (ba_nib == key_cur);
  // After a mismatch the nibble may still be the start of a new attempt.
  assign nib_first = (ba_nib == UNLOCK_KEY[NIB_W-1:0]);
  assign is_clr    = (ba_nib == CLR_NIB);
  assign last_bit  = (cnt_q == CNT_W'(MAX_BITS - 1));
  assign lfsr_next = {state_q[STATE_W-2:0], ^(state_q & TAPS)};

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= LOCKED;
      idx_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      state_q    <= SEED;
      unlocked_q <= 1'b0;
    end else begin
      acc_q <= acc;
      if (stp) begin
        case (fsm_q)
          LOCKED: begin
            state_q <= SEED;
            if (nib_hit) begin
              if (idx_q == IDX_W'(SEQ_LEN - 1)) begin
                fsm_q      <= RUN;
                unlocked_q <= 1'b1;
                cnt_q      <= '0;
                idx_q      <= '0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              idx_q <= nib_first ? IDX_W'(1) : '0;
            end
          end
          RUN: begin
            // The final bit still advances the LFSR, but the relock that
            // follows reloads SEED on the same edge, so only SEED is seen.
            if (is_clr || last_bit) begin
              fsm_q      <= LOCKED;
              unlocked_q <= 1'b0;
              idx_q      <= '0;
              cnt_q      <= '0;
              state_q    <= SEED;
            end else begin
              state_q <= lfsr_next;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
          default: begin
            fsm_q      <= LOCKED;
            unlocked_q <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            state_q    <= SEED;
          end
        endcase
      end
    end
  end

  // The data bit is the pre-advance value, since state only moves on the edge.
  assign sdrd     = ^(state_q & OUT_MASK);
  assign sdrd_oe  = acc & unlocked_q;
  assign unlocked = unlocked_q;
  assign state    = state_q;
  assign dbg_idx  = 3'(idx_q);
  assign dbg_cnt  = 16'(cnt_q);

endmodule

// File: tb/tb_serial_key_seq.sv
module tb_serial_key_seq;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       sser, ba13, ba12, br_w;
  logic [3:0] ba_nib;

  // default build
  logic        a_sdrd, a_oe, a_unlocked;
  logic [5:0]  a_state;
  logic [2:0]  a_dbg_idx;
  logic [15:0] a_dbg_cnt;

  // 8-bit state, two-nibble key build
  logic        b_sdrd, b_oe, b_unlocked;
  logic [7:0]  b_state;
  logic [2:0]  b_dbg_idx;
  logic [15:0] b_dbg_cnt;

  serial_key_seq dut_a (
    .clk(clk), .rst(rst), .sser(sser), .ba13(ba13), .ba12(ba12),
    .ba_nib(ba_nib), .br_w(br_w), .sdrd(a_sdrd), .sdrd_oe(a_oe),
    .unlocked(a_unlocked), .state(a_state), .dbg_idx(a_dbg_idx),
    .dbg_cnt(a_dbg_cnt)
  );

  serial_key_seq #(
    .STATE_W(8), .SEQ_LEN(2), .SEED(8'hA5), .TAPS(8'hB8), .OUT_MASK(8'hFF)
  ) dut_b (
    .clk(clk), .rst(rst), .sser(sser), .ba13(ba13), .ba12(ba12),
    .ba_nib(ba_nib), .br_w(br_w), .sdrd(b_sdrd), .sdrd_oe(b_oe),
    .unlocked(b_unlocked), .state(b_state), .dbg_idx(b_dbg_idx),
    .dbg_cnt(b_dbg_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (default build) ----------------
  // Key nibbles in presentation order, and the behavioural view:
  // locked with a count of matched nibbles, or running with bits served.
  int         key_a[4] = '{12, 3, 10, 5};
  int         m_run, m_idx, m_cnt;
  logic [5:0] m_st;

  function automatic logic par(input logic [31:0] v);
    return logic'($countones(v) % 2);
  endfunction

  function automatic logic [5:0] lfsr6(input logic [5:0] s);
    int v;
    v = ((int'(s) * 2) + int'(par(32'(s & 6'h29)))) % 64;
    return 6'(v);
  endfunction

  task automatic model_relock();
    m_run = 0; m_idx = 0; m_cnt = 0; m_st = 6'h29;
  endtask

  task automatic model_step(input int nib);
    if (m_run == 0) begin
      if (nib == key_a[m_idx]) begin
        if (m_idx == 3) begin m_run = 1; m_idx = 0; m_cnt = 0; end
        else m_idx++;
      end else begin
        m_idx = (nib == key_a[0]) ? 1 : 0;
      end
    end else if (nib == 15) begin
      model_relock();
    end else begin
      m_st = lfsr6(m_st);
      m_cnt++;
      if (m_cnt == 64) model_relock();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    sser = 1'b1; ba13 = 1'b0; ba12 = 1'b0; br_w = 1'b0; ba_nib = 4'h0;
  endtask

  // dec: 0 = window decodes, 1 = sser high, 2 = ba13 high, 3 = ba12 low
  task automatic set_bus(input logic [3:0] nib, input logic rd, input int dec);
    sser = (dec == 1); ba13 = (dec == 2); ba12 = (dec != 3); br_w = rd; ba_nib = nib;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_state"}, 32'(a_state), 32'(m_st));
    check({tag, "_unlk"}, 32'(a_unlocked), 32'(m_run));
    check({tag, "_idx"}, 32'(a_dbg_idx), 32'(m_idx));
    check({tag, "_cnt"}, 32'(a_dbg_cnt), 32'(m_cnt));
    check({tag, "_oe_idle"}, 32'(a_oe), 32'd0);
  endtask

  task automatic do_access(input logic [3:0] nib, input int ncyc, input logic rd, input int dec);
    @(negedge clk);
    set_bus(nib, rd, dec);
    for (int c = 0; c < ncyc; c++) begin
      #1;
      check("oe", 32'(a_oe), 32'((rd && dec == 0 && m_run != 0) ? 1 : 0));
      exp_q.push_back(32'(par(32'(m_st & 6'h29))));
      check("sdrd", 32'(a_sdrd), exp_q.pop_front());
      check("state_cyc", 32'(a_state), 32'(m_st));
      @(posedge clk);
      if (c == 0 && rd && dec == 0) model_step(int'(nib));
      @(negedge clk);
    end
    idle_bus();
    #1;
    check_quiet("acc");
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_bus();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_relock();
    #1;
  endtask

  task automatic do_unlock();
    for (int i = 0; i < 4; i++) do_access(4'(key_a[i]), 1, 1'b1, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int seq_n[6] = '{12, 3, 12, 3, 10, 5};
    int seq_i[5] = '{1, 2, 1, 2, 3};
    rst = 1'b1;
    idle_bus();
    model_relock();
    repeat (2) @(posedge clk);
    do_reset();

    // reset state
    check("rst_state", 32'(a_state), 32'h29);
    check("rst_unlk", 32'(a_unlocked), 32'd0);
    check("rst_oe", 32'(a_oe), 32'd0);
    check("rst_sdrd", 32'(a_sdrd), 32'd1);
    check_quiet("rst");

    // unlock, then a three-cycle data access
    do_unlock();
    check("unlock", 32'(a_unlocked), 32'd1);
    do_access(4'h0, 3, 1'b1, 0);
    check("first_bit_state", 32'(a_state), 32'h13);

    // overlapping attempt with a write in the middle
    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_access(4'(seq_n[i]), 1, 1'b1, 0);
      if (i < 5) check("seq_idx", 32'(a_dbg_idx), 32'(seq_i[i]));
      if (i == 2) begin
        do_access(4'hC, 1, 1'b0, 0);
        check("write_idx", 32'(a_dbg_idx), 32'd1);
      end
    end
    check("seq_unlock", 32'(a_unlocked), 32'd1);

    // bit budget exhaustion; the last access straddles the relock
    do_reset();
    do_unlock();
    for (int k = 1; k <= 64; k++) begin
      do_access(4'($urandom_range(0, 14)), (k == 64) ? 2 : 1, 1'b1, 0);
      if (k == 63) check("budget_63", 32'(a_unlocked), 32'd1);
    end
    check("budget_unlk", 32'(a_unlocked), 32'd0);
    check("budget_state", 32'(a_state), 32'h29);
    do_access(4'h0, 2, 1'b1, 0);

    // clear nibble in RUN
    do_reset();
    do_unlock();
    do_access(4'h1, 1, 1'b1, 0);
    do_access(4'hF, 2, 1'b1, 0);
    check("clr_unlk", 32'(a_unlocked), 32'd0);
    check("clr_state", 32'(a_state), 32'h29);

    // reset beats a concurrent step; an access held across release steps once
    do_reset();
    do_access(4'hC, 1, 1'b1, 0);
    @(negedge clk);
    rst = 1'b1;
    set_bus(4'h3, 1'b1, 0);
    @(posedge clk);
    model_relock();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_prio_idx", 32'(a_dbg_idx), 32'd0);
    @(posedge clk);
    model_step(3);
    @(negedge clk);
    #1;
    check("rst_release_idx", 32'(a_dbg_idx), 32'(m_idx));
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    #1;
    check_quiet("rst_hold");

    // reset during RUN
    do_reset();
    do_unlock();
    do_reset();
    check("rst_run_unlk", 32'(a_unlocked), 32'd0);

    // 8-bit build, two-nibble key, reset after first nibble
    do_access(4'hC, 1, 1'b1, 0);
    check("b_idx1", 32'(b_dbg_idx), 32'd1);
    do_reset();
    check("b_rst_idx", 32'(b_dbg_idx), 32'd0);
    check("b_rst_state", 32'(b_state), 32'hA5);
    do_access(4'hC, 1, 1'b1, 0);
    do_access(4'h3, 1, 1'b1, 0);
    check("b_unlock", 32'(b_unlocked), 32'd1);
    check("b_sdrd", 32'(b_sdrd), 32'd0);
    do_access(4'h0, 1, 1'b1, 0);
    check("b_state_adv", 32'(b_state), 32'h4A);
    check("b_cnt", 32'(b_dbg_cnt), 32'd1);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int dec;
      int nib;
      logic rd;
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
        check_quiet("rnd_rst");
      end
      dec = ($urandom_range(0, 99) < 85) ? 0 : int'($urandom_range(1, 3));
      rd  = ($urandom_range(0, 99) < 90);
      if (m_run == 0)
        nib = ($urandom_range(0, 99) < 60) ? key_a[m_idx] : int'($urandom_range(0, 15));
      else
        nib = ($urandom_range(0, 99) < 3) ? 15 : int'($urandom_range(0, 14));
      do_access(4'(nib), int'($urandom_range(1, 3)), rd, dec);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
